// File: rtl/i2c_top.sv
// i2c_top: a single-master I2C-style bus with one internal slave, both on
// shared SDA/SCL nets.
// Build option: define I2C_TOP_ADDR_CHECK_EN to make the slave acknowledge
// only SLAVE_ADDR. Without it, the slave acknowledges every address.
// Request protocol: there is no valid/ready pair. enable is a level request
// that is sampled only in IDLE. Once a frame starts it runs to STOP, and
// inputs that change during the frame are ignored.
module i2c_top #(
  parameter int         CLK_DIV    = 1,
  parameter logic [6:0] SLAVE_ADDR = 7'b0000110,
  parameter logic [3:0] SLAVE_INIT = 4'b1010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr_top,
  input  logic [3:0] data_in_top,
  input  logic       enable,
  input  logic       rd_wr,
  output logic [3:0] data_out,
  output logic [3:0] slave_data_out,
  output logic       sda,
  output logic       scl
);

  localparam int             PW   = $clog2(2 * CLK_DIV + 1);
  localparam logic [PW-1:0]  HALF = PW'(CLK_DIV);
  localparam logic [PW-1:0]  LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0]  ONE  = PW'(1);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, RW, ACK1, DATA, ACK2, STOP
  } m_state_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RW, S_ACK1, S_DATA, S_ACK2, S_WAIT
  } s_state_e;

  // master state
  m_state_e      m_state_q, m_state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    wdata_q, wdata_d;
  logic          rw_q, rw_d;
  logic          ack_q, ack_d;
  logic [3:0]    rdata_q, rdata_d;
  logic [3:0]    data_out_q, data_out_d;
  logic          idle_wait_q, idle_wait_d;

  // slave state
  s_state_e      s_state_q, s_state_d;
  logic [2:0]    s_cnt_q, s_cnt_d;
  logic [6:0]    addr_sh_q, addr_sh_d;
  logic          s_rw_q, s_rw_d;
  logic [3:0]    data_sh_q, data_sh_d;
  logic [3:0]    reg_q, reg_d;
  logic          nxt_q, nxt_d;   // slave drive for the upcoming bit period
  logic          cur_q, cur_d;   // slave drive for the current bit period
  logic          scl_prev_q, scl_prev_d;
  logic          sda_prev_q, sda_prev_d;

  // bus nets
  logic m_sda, s_sda, scl_int, scl_high;
  logic sample, bit_end, ack_now;
  logic rise, fall, start_seen, addr_match, addr_ok;

  assign scl            = scl_int;
  assign sda            = m_sda & s_sda;
  assign data_out       = data_out_q;
  assign slave_data_out = reg_q;

  assign scl_high = (phase_q >= HALF);
  assign sample   = (phase_q == HALF);
  assign bit_end  = (phase_q == LAST);

  // Master bus drive. START holds SCL high so SDA can fall under a high clock.
  always_comb begin
    scl_int = 1'b1;
    m_sda   = 1'b1;
    case (m_state_q)
      START: m_sda = (phase_q < HALF);
      ADDR: begin
        scl_int = scl_high;
        m_sda   = addr_q[3'd6 - bit_cnt_q];
      end
      RW: begin
        scl_int = scl_high;
        m_sda   = rw_q;
      end
      ACK1:    scl_int = scl_high;
      DATA: begin
        scl_int = scl_high;
        m_sda   = rw_q ? 1'b1 : wdata_q[2'd3 - bit_cnt_q[1:0]];
      end
      ACK2:    scl_int = scl_high;
      STOP: begin
        scl_int = scl_high;
        m_sda   = 1'b0;
      end
      default: ;
    endcase
  end

  // Master next state. A bit period ends on phase LAST, and SDA is sampled on phase HALF.
  always_comb begin
    m_state_d   = m_state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    rdata_d     = rdata_q;
    data_out_d  = data_out_q;
    idle_wait_d = idle_wait_q;
    ack_now     = sample ? ~sda : ack_q;
    if (m_state_q != IDLE || idle_wait_q) begin
      phase_d = bit_end ? '0 : phase_q + ONE;
    end
    case (m_state_q)
      IDLE: begin
        if (!idle_wait_q || bit_end) begin
          idle_wait_d = 1'b0;
          if (enable) begin
            addr_d    = addr_top;
            wdata_d   = data_in_top;
            rw_d      = rd_wr;
            phase_d   = '0;
            m_state_d = START;
          end
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = 3'd0;
          m_state_d = ADDR;
        end
      end
      ADDR: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd6) begin
            bit_cnt_d = 3'd0;
            m_state_d = RW;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      RW: if (bit_end) m_state_d = ACK1;
      ACK1: begin
        ack_d = ack_now;
        if (bit_end) begin
          bit_cnt_d = 3'd0;
          m_state_d = ack_now ? DATA : STOP;
        end
      end
      DATA: begin
        if (sample && rw_q) rdata_d = {rdata_q[2:0], sda};
        if (bit_end) begin
          if (bit_cnt_q == 3'd3) begin
            bit_cnt_d = 3'd0;
            m_state_d = ACK2;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ACK2: begin
        if (bit_end) begin
          if (rw_q) data_out_d = rdata_q;
          m_state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          idle_wait_d = 1'b1;
          m_state_d   = IDLE;
        end
      end
      default: m_state_d = IDLE;
    endcase
  end

  // Master registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state_q   <= IDLE;
      phase_q     <= '0;
      bit_cnt_q   <= 3'd0;
      addr_q      <= 7'd0;
      wdata_q     <= 4'd0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= 4'd0;
      data_out_q  <= 4'd0;
      idle_wait_q <= 1'b0;
    end else begin
      m_state_q   <= m_state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      data_out_q  <= data_out_d;
      idle_wait_q <= idle_wait_d;
    end
  end

  // Slave bus drive. While SCL is low, the slave already shows the next bit's
  // value, so its SDA changes only in the low half.
  always_comb begin
    s_sda = scl_int ? cur_q : nxt_q;
  end

  assign rise       = scl_int & ~scl_prev_q;
  assign fall       = ~scl_int & scl_prev_q;
  assign start_seen = scl_int & scl_prev_q & sda_prev_q & ~sda;
  assign addr_match = (addr_sh_q == SLAVE_ADDR);

  // Address acceptance policy.
  always_comb begin
`ifdef I2C_TOP_ADDR_CHECK_EN
    addr_ok = addr_match;
`else
    // Every address is accepted. The comparison is kept so both builds share one datapath.
    addr_ok = 1'b1 | addr_match;
`endif
  end

  // Slave next state. It advances on SCL rises and commits drive and loads on SCL falls.
  always_comb begin
    s_state_d  = s_state_q;
    s_cnt_d    = s_cnt_q;
    addr_sh_d  = addr_sh_q;
    s_rw_d     = s_rw_q;
    data_sh_d  = data_sh_q;
    reg_d      = reg_q;
    nxt_d      = nxt_q;
    cur_d      = cur_q;
    scl_prev_d = scl_int;
    sda_prev_d = sda;
    if (start_seen) begin
      s_state_d = S_ADDR;
      s_cnt_d   = 3'd0;
      nxt_d     = 1'b1;
      cur_d     = 1'b1;
    end else begin
      if (fall) begin
        cur_d = nxt_q;
        if (s_state_q == S_ACK2 && !s_rw_q) reg_d = data_sh_q;
      end
      if (rise) begin
        case (s_state_q)
          S_ADDR: begin
            addr_sh_d = {addr_sh_q[5:0], sda};
            if (s_cnt_q == 3'd6) begin
              s_cnt_d   = 3'd0;
              s_state_d = S_RW;
            end else begin
              s_cnt_d = s_cnt_q + 3'd1;
            end
          end
          S_RW: begin
            s_rw_d    = sda;
            nxt_d     = ~addr_ok;
            s_state_d = S_ACK1;
          end
          S_ACK1: begin
            s_cnt_d = 3'd0;
            if (addr_ok) begin
              nxt_d     = s_rw_q ? reg_q[3] : 1'b1;
              s_state_d = S_DATA;
            end else begin
              nxt_d     = 1'b1;
              s_state_d = S_WAIT;
            end
          end
          S_DATA: begin
            data_sh_d = {data_sh_q[2:0], sda};
            if (s_cnt_q == 3'd3) begin
              nxt_d     = s_rw_q;
              s_state_d = S_ACK2;
            end else begin
              s_cnt_d = s_cnt_q + 3'd1;
              nxt_d   = s_rw_q ? reg_q[2'd2 - s_cnt_q[1:0]] : 1'b1;
            end
          end
          S_ACK2: begin
            nxt_d     = 1'b1;
            s_state_d = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Slave registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_state_q  <= S_IDLE;
      s_cnt_q    <= 3'd0;
      addr_sh_q  <= 7'd0;
      s_rw_q     <= 1'b0;
      data_sh_q  <= 4'd0;
      reg_q      <= SLAVE_INIT;
      nxt_q      <= 1'b1;
      cur_q      <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      s_state_q  <= s_state_d;
      s_cnt_q    <= s_cnt_d;
      addr_sh_q  <= addr_sh_d;
      s_rw_q     <= s_rw_d;
      data_sh_q  <= data_sh_d;
      reg_q      <= reg_d;
      nxt_q      <= nxt_d;
      cur_q      <= cur_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

endmodule

// File: tb/tb_i2c_top.sv
// tb_i2c_top: directed checks of i2c_top with CLK_DIV = 1.
// Frame timing: enable is seen at edge P0, and the frame is then on the bus for
// cycles 0..31, with each bit taking one even (SCL low) cycle and one odd (SCL high) cycle.
module tb_i2c_top;

  logic       clk;
  logic       rst;
  logic [6:0] addr_top;
  logic [3:0] data_in_top;
  logic       enable;
  logic       rd_wr;
  logic [3:0] data_out;
  logic [3:0] slave_data_out;
  logic       sda;
  logic       scl;

  int checks;
  int errors;
  logic [3:0] exp_reg;
  logic       sda_log [0:127];
  logic       scl_log [0:127];
  logic [3:0] sdo_log [0:127];

  i2c_top dut (
    .clk            (clk),
    .rst            (rst),
    .addr_top       (addr_top),
    .data_in_top    (data_in_top),
    .enable         (enable),
    .rd_wr          (rd_wr),
    .data_out       (data_out),
    .slave_data_out (slave_data_out),
    .sda            (sda),
    .scl            (scl)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses enable for one edge. The task returns at the negedge of cycle 0.
  task automatic start_frame(input logic [6:0] a, input logic [3:0] d, input logic rw);
    @(negedge clk);
    addr_top    = a;
    data_in_top = d;
    rd_wr       = rw;
    enable      = 1'b1;
    @(negedge clk);
    enable      = 1'b0;
  endtask

  // Records the bus for cycles first..first+n-1, one sample per negedge.
  task automatic log_bus(input int first, input int n);
    for (int c = first; c < first + n; c++) begin
      sda_log[c] = sda;
      scl_log[c] = scl;
      sdo_log[c] = slave_data_out;
      @(negedge clk);
    end
  endtask

  // Packs the SDA values seen in the 16 SCL-high cycles of a frame that starts at cycle base.
  function automatic logic [15:0] hi_bits(input int base);
    logic [15:0] v;
    for (int k = 0; k < 16; k++) v[15-k] = sda_log[base + 2*k + 1];
    return v;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", scl); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
    checks++; if (data_out !== 4'b0000) begin errors++; $display("FAIL reset_data_out: got %b want 0000", data_out); end
    checks++; if (slave_data_out !== 4'b1010) begin errors++; $display("FAIL reset_slave_data: got %b want 1010", slave_data_out); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({scl, sda} !== 2'b11) begin errors++; $display("FAIL idle_after_reset: got scl/sda %b want 11", {scl, sda}); end
  endtask

  task automatic test_read;
    int bad_scl;
    start_frame(7'b0000110, 4'b0000, 1'b1);
    log_bus(0, 32);
    // START 0, addr 0000110, R 1, ACK 0, data 1010, NACK 1, STOP high half 0
    checks++; if (hi_bits(0) !== 16'b0_0000110_1_0_1010_1_0) begin
      errors++; $display("FAIL read_frame: got %b want %b", hi_bits(0), 16'b0_0000110_1_0_1010_1_0); end
    checks++; if ({scl_log[0], sda_log[0]} !== 2'b11) begin
      errors++; $display("FAIL read_start_first_half: got %b want 11", {scl_log[0], sda_log[0]}); end
    bad_scl = 0;
    for (int k = 1; k < 16; k++) if (scl_log[2*k] !== 1'b0 || scl_log[2*k+1] !== 1'b1) bad_scl++;
    checks++; if (bad_scl != 0) begin errors++; $display("FAIL read_scl_pattern: got %0d bad periods want 0", bad_scl); end
    checks++; if (data_out !== 4'b1010) begin errors++; $display("FAIL read_data_out: got %b want 1010", data_out); end
    checks++; if ({scl, sda} !== 2'b11) begin errors++; $display("FAIL read_idle_after: got %b want 11", {scl, sda}); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write;
    start_frame(7'b0000110, 4'b1101, 1'b0);
    // Inputs change mid-frame and must not affect the frame already running.
    addr_top    = 7'b1111111;
    data_in_top = 4'b0000;
    rd_wr       = 1'b1;
    log_bus(0, 32);
    checks++; if (hi_bits(0) !== 16'b0_0000110_0_0_1101_0_0) begin
      errors++; $display("FAIL write_frame: got %b want %b", hi_bits(0), 16'b0_0000110_0_0_1101_0_0); end
    checks++; if (sdo_log[27] !== 4'b1010) begin errors++; $display("FAIL write_reg_before_ack2: got %b want 1010", sdo_log[27]); end
    checks++; if (sdo_log[29] !== 4'b1101) begin errors++; $display("FAIL write_reg_in_ack2: got %b want 1101", sdo_log[29]); end
    repeat (4) @(negedge clk);
    start_frame(7'b0000110, 4'b0000, 1'b1);
    log_bus(0, 32);
    checks++; if (data_out !== 4'b1101) begin errors++; $display("FAIL write_readback: got %b want 1101", data_out); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    start_frame(7'b0000110, 4'b0101, 1'b0);
    log_bus(0, 23);   // now in cycle 23: high half of data bit 1
    #2 rst = 1'b0;
    #1;
    checks++; if ({scl, sda} !== 2'b11) begin errors++; $display("FAIL midrst_bus: got %b want 11", {scl, sda}); end
    checks++; if (data_out !== 4'b0000) begin errors++; $display("FAIL midrst_data_out: got %b want 0000", data_out); end
    checks++; if (slave_data_out !== 4'b1010) begin errors++; $display("FAIL midrst_slave_data: got %b want 1010", slave_data_out); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (slave_data_out !== 4'b1010) begin errors++; $display("FAIL midrst_no_corrupt: got %b want 1010", slave_data_out); end
    start_frame(7'b0000110, 4'b0000, 1'b1);
    log_bus(0, 32);
    checks++; if (data_out !== 4'b1010) begin errors++; $display("FAIL midrst_readback: got %b want 1010", data_out); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_other_addr;
    start_frame(7'b1010100, 4'b0011, 1'b0);
    log_bus(0, 32);
`ifdef I2C_TOP_ADDR_CHECK_EN
    checks++; if (sda_log[19] !== 1'b1) begin errors++; $display("FAIL addr_nack: got %b want 1", sda_log[19]); end
    checks++; if ({scl_log[20], sda_log[20], scl_log[21], sda_log[21], scl_log[22], sda_log[22]} !== 6'b00_10_11) begin
      errors++; $display("FAIL addr_nack_stop: got %b want 001011",
        {scl_log[20], sda_log[20], scl_log[21], sda_log[21], scl_log[22], sda_log[22]}); end
    exp_reg = 4'b1010;
`else
    checks++; if (sda_log[19] !== 1'b0) begin errors++; $display("FAIL addr_any_ack: got %b want 0", sda_log[19]); end
    exp_reg = 4'b0011;
`endif
    checks++; if (slave_data_out !== exp_reg) begin errors++; $display("FAIL addr_slave_data: got %b want %b", slave_data_out, exp_reg); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n_start;
    int first_c;
    int second_c;
    n_start  = 0;
    first_c  = -1;
    second_c = -1;
    @(negedge clk);
    addr_top = 7'b0000110;
    rd_wr    = 1'b1;
    enable   = 1'b1;
    @(negedge clk);
    log_bus(0, 40);
    enable = 1'b0;
    log_bus(40, 60);
    for (int c = 1; c < 100; c++) begin
      if (scl_log[c] && scl_log[c-1] && sda_log[c-1] && !sda_log[c]) begin
        n_start++;
        if (first_c < 0) first_c = c;
        else if (second_c < 0) second_c = c;
      end
    end
    checks++; if (n_start != 2) begin errors++; $display("FAIL b2b_start_count: got %0d want 2", n_start); end
    checks++; if (second_c - first_c != 34) begin errors++; $display("FAIL b2b_spacing: got %0d want 34", second_c - first_c); end
    checks++; if ({scl_log[32], sda_log[32], scl_log[33], sda_log[33]} !== 4'b1111) begin
      errors++; $display("FAIL b2b_idle_period: got %b want 1111", {scl_log[32], sda_log[32], scl_log[33], sda_log[33]}); end
    checks++; if (hi_bits(34) !== {5'b0_0000, 3'b110, 1'b1, 1'b0, exp_reg, 2'b10}) begin
      errors++; $display("FAIL b2b_second_frame: got %b want %b", hi_bits(34), {5'b0_0000, 3'b110, 1'b1, 1'b0, exp_reg, 2'b10}); end
    checks++; if (data_out !== exp_reg) begin errors++; $display("FAIL b2b_data_out: got %b want %b", data_out, exp_reg); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_reg     = 4'b1010;
    rst         = 1'b1;
    enable      = 1'b0;
    addr_top    = 7'd0;
    data_in_top = 4'd0;
    rd_wr       = 1'b0;
    #1;
    test_reset;
    test_read;
    test_write;
    test_reset_mid_frame;
    test_other_addr;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
